// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator scheduler.
// The optional emergency stop is enabled by defining ELEV_ESTOP_EN.
package elevator_pkg;

   localparam int FLOOR_W            = 3;
   localparam int DEF_NUM_FLOORS     = 5;
   localparam int DEF_TRAVEL_CYCLES  = 8;
   localparam int DEF_DOOR_CYCLES    = 4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_e;

   // Width of a down-counter whose largest load value is max_val.
   function automatic int cnt_w(input int max_val);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) <= max_val) begin
            w = i + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/elevator_call_latch.sv
// Sticky pending-call register with one-hot clear, plus reductions of the
// outstanding calls above and below a reference floor.
module elevator_call_latch #(
   parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
   parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_FLOORS-1:0] i_set,
   input  logic [NUM_FLOORS-1:0] i_clr,
   input  logic [FLOOR_W-1:0]    i_floor,
   output logic [NUM_FLOORS-1:0] o_pending,
   output logic                  o_above,
   output logic                  o_below
);

   logic [NUM_FLOORS-1:0] r_pending;
   logic                  w_above;
   logic                  w_below;

   // Pending register: new calls set, the served floor clears (clear wins).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pending <= {NUM_FLOORS{1'b0}};
      end else begin
         r_pending <= (r_pending | i_set) & ~i_clr;
      end
   end

   // Any outstanding call strictly above / below the reference floor.
   always_comb begin
      w_above = 1'b0;
      w_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_above = w_above | (r_pending[i] & (FLOOR_W'(i) > i_floor));
         w_below = w_below | (r_pending[i] & (FLOOR_W'(i) < i_floor));
      end
   end

   assign o_pending = r_pending;
   assign o_above   = w_above;
   assign o_below   = w_below;

endmodule

// File: rtl/elevator_scheduler_chk.sv
// Protocol checks for the scheduler: the car never heads past the end floors.
module elevator_scheduler_chk #(
   parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
   parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
   input logic               i_clk,
   input logic               i_rst,
   input logic [FLOOR_W-1:0] i_floor,
   input logic               i_dir,
   input logic               i_moving
);

   a_floor_range: assert property (@(posedge i_clk) disable iff (i_rst)
      i_floor <= FLOOR_W'(NUM_FLOORS - 1));

   a_no_up_at_top: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_moving && (i_dir == elevator_pkg::DIR_UP) && (i_floor == FLOOR_W'(NUM_FLOORS - 1))));

   a_no_down_at_ground: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_moving && (i_dir == elevator_pkg::DIR_DOWN) && (i_floor == {FLOOR_W{1'b0}})));

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator car scheduler with travel and door timers.
// Define ELEV_ESTOP_EN to add the i_estop freeze input.
module elevator_scheduler #(
   parameter int NUM_FLOORS    = elevator_pkg::DEF_NUM_FLOORS,
   parameter int FLOOR_W       = elevator_pkg::FLOOR_W,
   parameter int TRAVEL_CYCLES = elevator_pkg::DEF_TRAVEL_CYCLES,
   parameter int DOOR_CYCLES   = elevator_pkg::DEF_DOOR_CYCLES
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
`ifdef ELEV_ESTOP_EN
   input  logic                  i_estop,
`endif
   input  logic [NUM_FLOORS-1:0] i_call_req,
   output logic [FLOOR_W-1:0]    o_floor,
   output logic                  o_dir,
   output logic                  o_moving,
   output logic                  o_door_open,
   output logic                  o_arrive,
   output logic [NUM_FLOORS-1:0] o_pending
);

   import elevator_pkg::*;

   localparam int CNT_MAX = ((TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES) - 1;
   localparam int CNT_W   = cnt_w(CNT_MAX);
   localparam logic [CNT_W-1:0]      TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0]      DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [CNT_W-1:0]      CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_FLOORS-1:0] ONE_HOT0    = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
   localparam logic [FLOOR_W-1:0]    FLOOR_ONE   = {{(FLOOR_W-1){1'b0}}, 1'b1};

   state_e                r_state, w_state_nxt;
   logic [FLOOR_W-1:0]    r_floor, w_floor_nxt, w_next_floor;
   logic                  r_dir, w_dir_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  r_arrive, w_arrive_nxt;
   logic                  r_moving;
   logic                  r_door;
   logic [NUM_FLOORS-1:0] w_clr;
   logic [NUM_FLOORS-1:0] w_pending;
   logic [NUM_FLOORS-1:0] w_here_oh, w_next_oh;
   logic                  w_above, w_below;
   logic                  w_pend_here, w_pend_next, w_call_here;
   logic                  w_run;

`ifdef ELEV_ESTOP_EN
   assign w_run = ~i_estop;
`else
   assign w_run = 1'b1;
`endif

   elevator_call_latch #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_call_latch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_set     (i_call_req),
      .i_clr     (w_clr),
      .i_floor   (r_floor),
      .o_pending (w_pending),
      .o_above   (w_above),
      .o_below   (w_below)
   );

   // Floor the car reaches on its next step in the current direction.
   always_comb begin
      if (r_dir == DIR_UP) begin
         w_next_floor = r_floor + FLOOR_ONE;
      end else begin
         w_next_floor = r_floor - FLOOR_ONE;
      end
   end

   // Shifting past the top floor yields zero, so no out-of-range indexing.
   assign w_here_oh   = ONE_HOT0 << r_floor;
   assign w_next_oh   = ONE_HOT0 << w_next_floor;
   assign w_pend_here = |(w_pending & w_here_oh);
   assign w_pend_next = |(w_pending & w_next_oh);
   assign w_call_here = |(i_call_req & w_here_oh);

   // Next-state, counter and pending-clear logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_floor_nxt  = r_floor;
      w_dir_nxt    = r_dir;
      w_cnt_nxt    = r_cnt;
      w_arrive_nxt = 1'b0;
      w_clr        = {NUM_FLOORS{1'b0}};
      case (r_state)
         ST_IDLE: begin
            if (!w_run) begin
               w_state_nxt = r_state;
            end else if (w_pend_here) begin
               w_state_nxt = ST_DOOR;
               w_clr       = w_here_oh;
               w_cnt_nxt   = DOOR_LOAD;
            end else if (w_above || w_below) begin
               w_state_nxt = ST_MOVE;
               w_cnt_nxt   = TRAVEL_LOAD;
               if (w_above && ((r_dir == DIR_UP) || !w_below)) begin
                  w_dir_nxt = DIR_UP;
               end else begin
                  w_dir_nxt = DIR_DOWN;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_MOVE: begin
            if (!w_run) begin
               w_state_nxt = r_state;
            end else if (r_cnt != CNT_ZERO) begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end else begin
               w_floor_nxt  = w_next_floor;
               w_arrive_nxt = 1'b1;
               // Beyond-check uses the old floor: the new floor's bit is known clear here.
               if (w_pend_next) begin
                  w_state_nxt = ST_DOOR;
                  w_clr       = w_next_oh;
                  w_cnt_nxt   = DOOR_LOAD;
               end else if ((r_dir == DIR_UP) ? w_above : w_below) begin
                  w_cnt_nxt = TRAVEL_LOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_DOOR: begin
            w_clr = w_here_oh;
            if (!w_run) begin
               w_state_nxt = r_state;
            end else if (w_call_here) begin
               w_cnt_nxt = DOOR_LOAD;
            end else if (r_cnt == CNT_ZERO) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, position and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_floor  <= {FLOOR_W{1'b0}};
         r_dir    <= DIR_UP;
         r_cnt    <= CNT_ZERO;
         r_arrive <= 1'b0;
         r_moving <= 1'b0;
         r_door   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_floor  <= w_floor_nxt;
         r_dir    <= w_dir_nxt;
         r_cnt    <= w_cnt_nxt;
         r_arrive <= w_arrive_nxt;
         r_moving <= (w_state_nxt == ST_MOVE);
         r_door   <= (w_state_nxt == ST_DOOR);
      end
   end

   assign o_floor     = r_floor;
   assign o_dir       = r_dir;
   assign o_moving    = r_moving;
   assign o_door_open = r_door;
   assign o_arrive    = r_arrive;
   assign o_pending   = w_pending;

   elevator_scheduler_chk #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_chk (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_floor  (r_floor),
      .i_dir    (r_dir),
      .i_moving (r_moving)
   );

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed table-driven bench for elevator_scheduler (default 5 floors, 8/4 cycle timers).
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] call;
   logic [2:0] floor;
   logic       dir, moving, door_open, arrive;
   logic [4:0] pending;
`ifdef ELEV_ESTOP_EN
   logic       estop = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   elevator_scheduler dut (
      .i_clk       (clk),
      .i_rst       (rst),
`ifdef ELEV_ESTOP_EN
      .i_estop     (estop),
`endif
      .i_call_req  (call),
      .o_floor     (floor),
      .o_dir       (dir),
      .o_moving    (moving),
      .o_door_open (door_open),
      .o_arrive    (arrive),
      .o_pending   (pending)
   );

   typedef struct {
      logic       rst;
      logic [4:0] call;
      int         n;
      logic [2:0] fl;
      logic       dir;
      logic       mv;
      logic       door;
      logic       arr;
      logic [4:0] pend;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic [4:0] c, input int n,
                              input logic [2:0] fl, input logic d, input logic mv,
                              input logic dr, input logic ar, input logic [4:0] p);
      vec_t t;
      t.rst = r; t.call = c; t.n = n; t.fl = fl; t.dir = d;
      t.mv = mv; t.door = dr; t.arr = ar; t.pend = p;
      return t;
   endfunction

   // One clock edge with the given inputs; outputs are sampled 1 time unit later.
   task automatic step(input logic r, input logic [4:0] c);
      rst  = r;
      call = c;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      call = 5'b00000;
   endtask

   task automatic check_out(input string nm, input logic [2:0] fl, input logic d,
                            input logic mv, input logic dr, input logic ar,
                            input logic [4:0] p);
      logic [12:0] got, exp;
      got = {floor, dir, moving, door_open, arrive, pending};
      exp = {fl, d, mv, dr, ar, p};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got floor=%0d dir=%b mv=%b door=%b arr=%b pend=%b, need floor=%0d dir=%b mv=%b door=%b arr=%b pend=%b",
                  nm, floor, dir, moving, door_open, arrive, pending, fl, d, mv, dr, ar, p);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, need %0d", nm, got, exp);
      end
   endtask

   initial begin
      int n;
      int arrivals;
      int open_cycles;
      rst  = 1'b1;
      call = 5'b00000;

      //                rst  call     n   fl  dir mv door arr pend
      tbl.push_back(v(1'b1, 5'b00000, 2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000)); // reset state
      tbl.push_back(v(1'b0, 5'b00100, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100)); // E0 latch
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100)); // E1 MOVE up
      tbl.push_back(v(1'b0, 5'b00000, 7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100)); // E1+7
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00100)); // E1+8 floor 1
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100)); // arrive one cycle
      tbl.push_back(v(1'b0, 5'b00000, 6, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100)); // E1+15
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000)); // E1+16 door
      tbl.push_back(v(1'b0, 5'b00000, 3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000)); // 4th door cycle
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000)); // idle
      tbl.push_back(v(1'b0, 5'b00100, 1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100)); // call here
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000)); // door, no move
      tbl.push_back(v(1'b0, 5'b00000, 4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));
      tbl.push_back(v(1'b1, 5'b00000, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000)); // reset
      tbl.push_back(v(1'b0, 5'b00001, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00001)); // ground call
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000));
      tbl.push_back(v(1'b0, 5'b00000, 4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));
      tbl.push_back(v(1'b0, 5'b10000, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000)); // call top
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000));
      tbl.push_back(v(1'b0, 5'b00000, 16, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10000));
      tbl.push_back(v(1'b0, 5'b00000, 3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000));
      tbl.push_back(v(1'b0, 5'b00010, 1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10010)); // call behind
      tbl.push_back(v(1'b0, 5'b00000, 4, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10010)); // passes 3
      tbl.push_back(v(1'b0, 5'b00000, 8, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00010)); // stop at 4
      tbl.push_back(v(1'b0, 5'b00000, 4, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010));
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010)); // reverse
      tbl.push_back(v(1'b0, 5'b00000, 8, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00010));
      tbl.push_back(v(1'b0, 5'b00000, 16, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00000)); // serve 1
      tbl.push_back(v(1'b0, 5'b00000, 4, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000));
      tbl.push_back(v(1'b0, 5'b01000, 1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01000));
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b01000)); // only above: up
      tbl.push_back(v(1'b0, 5'b00000, 16, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000)); // door at 3
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000));
      tbl.push_back(v(1'b0, 5'b01000, 1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000)); // reload
      tbl.push_back(v(1'b0, 5'b00000, 3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000)); // still open
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));
      tbl.push_back(v(1'b0, 5'b10010, 1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10010)); // both sides
      tbl.push_back(v(1'b0, 5'b00000, 1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10010)); // up first
      tbl.push_back(v(1'b0, 5'b00000, 8, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00010));
      tbl.push_back(v(1'b1, 5'b00000, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000)); // reset in door
      tbl.push_back(v(1'b0, 5'b00100, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100));
      tbl.push_back(v(1'b0, 5'b00000, 12, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100)); // between 1 and 2
      tbl.push_back(v(1'b1, 5'b00000, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000)); // reset in move
      tbl.push_back(v(1'b0, 5'b00000, 3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            step(tbl[i].rst, (k == 0) ? tbl[i].call : 5'b00000);
         end
         check_out($sformatf("vec%0d", i), tbl[i].fl, tbl[i].dir, tbl[i].mv,
                   tbl[i].door, tbl[i].arr, tbl[i].pend);
      end

      // Full trip 0 -> 4: door opens 33 edges after the call edge, after 4 arrivals.
      step(1'b0, 5'b10000);
      arrivals = 0;
      n = 0;
      for (int k = 1; k <= 60; k++) begin
         step(1'b0, 5'b00000);
         n = k;
         if (arrive) arrivals++;
         if (door_open) break;
      end
      check_int("trip_latency", n, 33);
      check_int("trip_arrivals", arrivals, 4);
      check_int("trip_floor", int'(floor), 4);
      open_cycles = 1;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 5'b00000);
         if (door_open) open_cycles++;
         else break;
      end
      check_int("door_width", open_cycles, 4);

`ifdef ELEV_ESTOP_EN
      // Freeze 10 cycles mid-travel: the first step slides from E1+8 to E1+18.
      step(1'b1, 5'b00000);
      step(1'b0, 5'b00100);
      step(1'b0, 5'b00000);
      for (int k = 0; k < 4; k++) step(1'b0, 5'b00000);
      estop = 1'b1;
      for (int k = 0; k < 10; k++) step(1'b0, 5'b00000);
      check_out("estop_frozen", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100);
      estop = 1'b0;
      for (int k = 0; k < 3; k++) step(1'b0, 5'b00000);
      check_out("estop_not_yet", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100);
      step(1'b0, 5'b00000);
      check_out("estop_arrive", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00100);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
